// File: rtl/ysyx_25040105_lsu_pkg.sv
// ysyx_25040105_lsu_pkg
//   Shared constants for the load/store unit: RV32I funct3 codes for the
//   memory access sizes and the 2-bit FSM state encoding.
package ysyx_25040105_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_25040105_lsu_align.sv
// ysyx_25040105_lsu_align
//   Purely combinational byte-lane steering for the LSU.
//   Build option: LSU_MISALIGN_TRAP_EN adds the misalignment check ports.
// Ports
//   addr_lo    in   2   low address bits of the latched access
//   funct3     in   3   RV32I funct3 of the latched access
//   wen        in   1   1 = store
//   wdata      in   32  unshifted store data
//   word       in   32  aligned memory word returned for a load
//   wmask      out  4   byte-lane enables (0 for loads)
//   wdata_sh   out  32  store data moved onto its byte lanes
//   rdata_ext  out  32  extracted and extended load value
//   chk_*      in       live (not yet latched) access, only with the trap option
//   misalign   out  1   live access is misaligned, only with the trap option
module ysyx_25040105_lsu_align
    import ysyx_25040105_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
`ifdef LSU_MISALIGN_TRAP_EN
    input  logic [1:0]  chk_addr_lo,
    input  logic [2:0]  chk_funct3,
    input  logic        chk_wen,
    output logic        misalign,
`endif
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lanes: bytes use the full offset, halves only a[1], words none.
    always_comb begin
        wmask    = 4'b0000;
        wdata_sh = wdata;
        case (funct3)
            F3_B: begin
                wdata_sh = wdata << {addr_lo, 3'b000};
                if (wen) wmask = 4'b0001 << addr_lo;
            end
            F3_H: begin
                wdata_sh = wdata << {addr_lo[1], 4'b0000};
                if (wen) wmask = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                if (wen) wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        rdata_ext = word;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'd0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'd0, half_sel};
            default: rdata_ext = word;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Stores only know B/H/W; funct3 100/101 on a store is a word access.
    always_comb begin
        misalign = 1'b0;
        case (chk_funct3)
            F3_B:    misalign = 1'b0;
            F3_H:    misalign = chk_addr_lo[0];
            F3_BU:   misalign = chk_wen ? (chk_addr_lo != 2'b00) : 1'b0;
            F3_HU:   misalign = chk_wen ? (chk_addr_lo != 2'b00) : chk_addr_lo[0];
            default: misalign = (chk_addr_lo != 2'b00);
        endcase
    end
`endif

endmodule

// File: rtl/ysyx_25040105_lsu.sv
// ysyx_25040105_lsu
//   Multi-cycle load/store unit behind the EXU. Accepts one access, issues a
//   single word-aligned request on the memory port, waits for the response
//   and hands the extended load value to write-back. One access in flight.
//   Build option: LSU_MISALIGN_TRAP_EN makes misaligned accesses finish
//   immediately with out_err=1 and no memory request; without it out_err=0.
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          access handshake from the EXU
//   in_addr/in_wdata/in_wen/in_funct3   access description
//   out_valid/out_ready        result handshake to write-back
//   out_rdata/out_err          load value (0 for stores), misalign flag
//   mem_req_*                  request channel (valid/ready, addr, wen, wdata, wmask)
//   mem_resp_valid/rdata       response channel, always accepted in WAIT
//
// state  | meaning
// IDLE   | ready for a new access
// REQ    | request presented, waiting for mem_req_ready
// WAIT   | request taken, waiting for mem_resp_valid
// DONE   | result presented, waiting for out_ready
module ysyx_25040105_lsu
    import ysyx_25040105_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                in_wen,
    input  logic [2:0]          in_funct3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    lsu_state_t        state_q, state_d;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        al_wmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misalign_now;
    logic              err_q;
`endif

    assign accept = in_valid && in_ready;

    ysyx_25040105_lsu_align u_align (
        .addr_lo     (addr_q[1:0]),
        .funct3      (f3_q),
        .wen         (wen_q),
        .wdata       (wdata_q),
        .word        (mem_resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .chk_addr_lo (in_addr[1:0]),
        .chk_funct3  (in_funct3),
        .chk_wen     (in_wen),
        .misalign    (misalign_now),
`endif
        .wmask       (al_wmask),
        .wdata_sh    (al_wdata),
        .rdata_ext   (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misalign_now ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ:   if (mem_req_ready)  state_d = S_WAIT;
            S_WAIT:  if (mem_resp_valid) state_d = S_DONE;
            S_DONE:  if (out_ready)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == S_IDLE);
        mem_req_valid = (state_q == S_REQ);
        out_valid     = (state_q == S_DONE);
    end

    // Access copy and result register. The result is cleared on accept so a
    // trapped access (which never sees WAIT) reports zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else if (accept) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            wen_q   <= in_wen;
            f3_q    <= in_funct3;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= misalign_now;
`endif
        end else if (state_q == S_WAIT && mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : al_rdata;
        end
    end

    assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = al_wdata;
    assign mem_req_wmask = al_wmask;
    assign out_rdata     = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign out_err       = err_q;
`else
    assign out_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// tb_ysyx_25040105_lsu
//   Self-checking bench for the LSU: directed vectors for the documented
//   examples, a reset-while-waiting case, then randomized accesses checked
//   against a byte-addressed memory model. Handles both build options of
//   LSU_MISALIGN_TRAP_EN.
module tb_ysyx_25040105_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] BASE = 32'h8000_0000;
    logic [7:0] mem_b [64];

    always #5 clk = ~clk;

    ysyx_25040105_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_wen         (in_wen),
        .in_funct3      (in_funct3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input int wa);
        return {mem_b[wa+3], mem_b[wa+2], mem_b[wa+1], mem_b[wa]};
    endfunction

    // One complete access; starts and ends just after a negedge with the DUT idle.
    task automatic do_access(
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic        wen,
        input  logic [2:0]  f3,
        input  int          rq_dly,
        input  int          rs_dly,
        input  int          o_dly,
        output logic [31:0] got_rd,
        output logic        got_err,
        output logic [3:0]  got_mask,
        output logic [31:0] got_wd
    );
        int          size, off, wa;
        bit          mis, sgn;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_mask;

        // Reference: access size from funct3; stores only know B/H/W.
        if (f3 == 3'b000 || (!wen && f3 == 3'b100))      size = 1;
        else if (f3 == 3'b001 || (!wen && f3 == 3'b101)) size = 2;
        else                                             size = 4;
        sgn = !wen && (f3 == 3'b000 || f3 == 3'b001);
        off = (size == 1) ? int'(a[1:0]) : ((size == 2) ? (a[1] ? 2 : 0) : 0);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        wa     = int'(a[5:2]) * 4;
        e_addr = {a[31:2], 2'b00};
        e_wd   = wd << (8 * off);
        for (int k = 0; k < 4; k++) e_mask[k] = wen && (k >= off) && (k < off + size);
        e_rd = 32'd0;
        for (int k = 0; k < size; k++) e_rd[8*k +: 8] = mem_b[wa + off + k];
        if (sgn && e_rd >= (32'd1 << (8*size - 1))) e_rd = e_rd - (32'd1 << (8*size));
        if (wen || mis) e_rd = 32'd0;
        got_mask = 4'b0000;
        got_wd   = 32'd0;

        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_addr   = a;
        in_wdata  = wd;
        in_wen    = wen;
        in_funct3 = f3;
        @(negedge clk);
        in_valid  = 1'b0;
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_wen    = 1'($urandom);
        in_funct3 = 3'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);

        if (mis) begin
            chk("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
            chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
        end else begin
            chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_addr", mem_req_addr, e_addr);
            chk("req_wen", {31'd0, mem_req_wen}, {31'd0, wen});
            chk("req_wmask", {28'd0, mem_req_wmask}, {28'd0, e_mask});
            if (wen) chk("req_wdata", mem_req_wdata, e_wd);
            got_mask = mem_req_wmask;
            got_wd   = mem_req_wdata;
            for (int i = 0; i < rq_dly; i++) begin
                mem_resp_valid = 1'($urandom);
                @(negedge clk);
                mem_resp_valid = 1'b0;
                chk("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("req_hold_addr", mem_req_addr, e_addr);
                chk("req_hold_wmask", {28'd0, mem_req_wmask}, {28'd0, e_mask});
                if (wen) chk("req_hold_wdata", mem_req_wdata, e_wd);
                chk("in_ready_req", {31'd0, in_ready}, 32'd0);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("req_dropped", {31'd0, mem_req_valid}, 32'd0);
            for (int i = 0; i < rs_dly; i++) begin
                @(negedge clk);
                chk("wait_no_out", {31'd0, out_valid}, 32'd0);
            end
            mem_resp_rdata = mem_word(wa);
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
            if (wen)
                for (int k = 0; k < 4; k++)
                    if (e_mask[k]) mem_b[wa + k] = e_wd[8*k +: 8];
            chk("out_valid", {31'd0, out_valid}, 32'd1);
        end

        chk("out_rdata", out_rdata, e_rd);
        chk("out_err", {31'd0, out_err}, {31'd0, mis});
        got_rd  = out_rdata;
        got_err = out_err;
        for (int i = 0; i < o_dly; i++) begin
            mem_resp_valid = 1'($urandom);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            chk("out_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("out_hold_rdata", out_rdata, e_rd);
            chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_dropped", {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] rd, wdo;
    logic        er;
    logic [3:0]  mk;

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_addr        = 32'hDEAD_BEEF;
        in_wdata       = 32'hCAFE_F00D;
        in_wen         = 1'b1;
        in_funct3      = 3'b010;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        mem_b[0] = 8'h01; mem_b[1] = 8'h7F; mem_b[2] = 8'hFF; mem_b[3] = 8'h80;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_req_wen", {31'd0, mem_req_wen}, 32'd0);
        chk("rst_req_wdata", mem_req_wdata, 32'd0);
        chk("rst_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_access(BASE + 3, 32'd0, 1'b0, 3'b000, 0, 0, 0, rd, er, mk, wdo);
        chk("lb_spec", rd, 32'hFFFF_FF80);
        do_access(BASE + 2, 32'd0, 1'b0, 3'b101, 0, 0, 0, rd, er, mk, wdo);
        chk("lhu_spec", rd, 32'h0000_80FF);
        do_access(BASE + 2, 32'd0, 1'b0, 3'b001, 0, 0, 0, rd, er, mk, wdo);
        chk("lh_spec", rd, 32'hFFFF_80FF);
        do_access(BASE, 32'd0, 1'b0, 3'b010, 0, 0, 0, rd, er, mk, wdo);
        chk("lw_spec", rd, 32'h80FF_7F01);
        do_access(BASE + 2, 32'd0, 1'b0, 3'b010, 0, 0, 0, rd, er, mk, wdo);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
`else
        chk("lw_trunc_rdata", rd, 32'h80FF_7F01);
        chk("lw_trunc_err", {31'd0, er}, 32'd0);
`endif
        do_access(BASE + 1, 32'h1234_56AB, 1'b1, 3'b000, 3, 1, 2, rd, er, mk, wdo);
        chk("sb_wmask", {28'd0, mk}, 32'h2);
        chk("sb_wdata", wdo, 32'h3456_AB00);
        chk("sb_rdata", rd, 32'd0);

        // Reset while waiting for the response; the orphaned response must vanish.
        in_valid  = 1'b1;
        in_addr   = BASE + 4;
        in_wen    = 1'b0;
        in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstw_req_valid", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_rdata = 32'h5555_AAAA;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw_no_out", {31'd0, out_valid}, 32'd0);
            chk("rstw_idle", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        do_access(BASE + 4, 32'd0, 1'b0, 3'b010, 0, 0, 0, rd, er, mk, wdo);
        chk("rstw_next_lw", rd, mem_word(4));

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic        w;
            logic [2:0]  f;
            w = 1'($urandom);
            f = 3'($urandom_range(0, 7));
            a = BASE + $urandom_range(0, 63);
`ifndef LSU_MISALIGN_TRAP_EN
            if (w) begin
                if (f == 3'b001)      a[0]   = 1'b0;
                else if (f != 3'b000) a[1:0] = 2'b00;
            end
`endif
            do_access(a, $urandom, w, f, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), rd, er, mk, wdo);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
